// File: rtl/pipeline_pkg.sv
// Shared pipeline types: instruction classes and MEM-stage FSM states.
package pipeline_pkg;

    typedef enum logic [3:0] {
        INST_TYPE_NOP    = 4'd0,
        INST_TYPE_ALU    = 4'd1,
        INST_TYPE_LOAD   = 4'd3,
        INST_TYPE_STORE  = 4'd4,
        INST_TYPE_BRANCH = 4'd5
    } inst_type_e;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_ACCESS,
        MEM_WAIT,
        MEM_DONE
    } mem_state_e;

    // True for instruction classes that need the data-memory port.
    function automatic logic is_mem_op(input logic [3:0] inst_type);
        return (inst_type == INST_TYPE_LOAD) || (inst_type == INST_TYPE_STORE);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for the MEM stage; expired marks the last allowed WAIT cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Count WAIT cycles; clear has priority so every access starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on the req/ack data port, stalls upstream until
// completion or timeout, resolves branches and registers results toward MEM/WB.
// Upstream PC, IF/ID, ID/EX and EX/MEM registers must use Stall as a hold enable.
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned loads/stores with BusError.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] In_Inst,
    input  logic [31:0] In_NewPC,
    input  logic [31:0] In_RegDataB,
    input  logic [31:0] In_ALUOutput,
    input  logic        In_Condition,
    input  logic [3:0]  In_InstNum,
    input  logic [3:0]  In_InstType,
    output logic        Dmem_Req,
    output logic        Dmem_We,
    output logic [31:0] Dmem_Addr,
    output logic [31:0] Dmem_WData,
    input  logic [31:0] Dmem_RData,
    input  logic        Dmem_Ack,
    output logic        Stall,
    output logic        BranchTaken,
    output logic [31:0] BranchTarget,
    output logic        BusError,
    output logic        Out_Valid,
    output logic [31:0] Out_Inst,
    output logic [31:0] Out_ALUOutput,
    output logic [31:0] Out_MemData,
    output logic [3:0]  Out_InstNum,
    output logic [3:0]  Out_InstType
);

    mem_state_e  state, state_next;
    logic        mem_op, misaligned;
    logic        cnt_clear, cnt_enable, cnt_expired;
    logic [31:0] cap_inst, cap_alu, rdata_q;
    logic [3:0]  cap_num, cap_type;

    assign mem_op = is_mem_op(In_InstType);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (In_ALUOutput[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Address, data and direction come straight from EX/MEM, which Stall holds steady.
    assign Dmem_Addr    = In_ALUOutput;
    assign Dmem_WData   = In_RegDataB;
    assign Dmem_We      = (In_InstType == INST_TYPE_STORE);
    assign BranchTarget = In_NewPC;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(cnt_expired)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= MEM_IDLE;
        else       state <= state_next;
    end

    // Next state and handshake outputs; all outputs forced low while reset is held.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_next  = state;
        Stall       = 1'b0;
        Dmem_Req    = 1'b0;
        BusError    = 1'b0;
        BranchTaken = 1'b0;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        case (state)
            MEM_IDLE: begin
                BranchTaken = (In_InstType == INST_TYPE_BRANCH) && In_Condition;
                if (mem_op && misaligned) begin
                    BusError = 1'b1;
                end else if (mem_op) begin
                    Stall      = 1'b1;
                    state_next = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                Stall      = 1'b1;
                Dmem_Req   = 1'b1;
                cnt_clear  = 1'b1;
                state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                Stall      = 1'b1;
                Dmem_Req   = 1'b1;
                cnt_enable = 1'b1;
                // An ack on the final allowed cycle still completes normally.
                if (Dmem_Ack) begin
                    state_next = MEM_DONE;
                end else if (cnt_expired) begin
                    BusError   = 1'b1;
                    state_next = MEM_DONE;
                end
            end
            MEM_DONE: begin
                state_next = MEM_IDLE;
            end
            default: begin
                state_next = MEM_IDLE;
            end
        endcase
        if (reset) begin
            Stall       = 1'b0;
            Dmem_Req    = 1'b0;
            BusError    = 1'b0;
            BranchTaken = 1'b0;
        end
    end

    // Capture memory ops, latch read data, and register results toward MEM/WB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Out_Valid     <= 1'b0;
            Out_Inst      <= '0;
            Out_ALUOutput <= '0;
            Out_MemData   <= '0;
            Out_InstNum   <= '0;
            Out_InstType  <= '0;
            cap_inst      <= '0;
            cap_alu       <= '0;
            cap_num       <= '0;
            cap_type      <= '0;
            rdata_q       <= '0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (mem_op && !misaligned) begin
                        Out_Valid <= 1'b0;
                        cap_inst  <= In_Inst;
                        cap_alu   <= In_ALUOutput;
                        cap_num   <= In_InstNum;
                        cap_type  <= In_InstType;
                    end else if (In_InstType == INST_TYPE_NOP) begin
                        Out_Valid <= 1'b0;
                    end else begin
                        Out_Valid     <= 1'b1;
                        Out_Inst      <= In_Inst;
                        Out_ALUOutput <= In_ALUOutput;
                        Out_MemData   <= '0;
                        Out_InstNum   <= In_InstNum;
                        Out_InstType  <= In_InstType;
                    end
                end
                MEM_WAIT: begin
                    if (Dmem_Ack) begin
                        rdata_q <= (cap_type == INST_TYPE_LOAD) ? Dmem_RData : '0;
                    end else if (cnt_expired) begin
                        rdata_q <= '0;
                    end
                end
                MEM_DONE: begin
                    Out_Valid     <= 1'b1;
                    Out_Inst      <= cap_inst;
                    Out_ALUOutput <= cap_alu;
                    Out_MemData   <= rdata_q;
                    Out_InstNum   <= cap_num;
                    Out_InstType  <= cap_type;
                end
                default: begin
                    Out_Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboard of expected MEM/WB results
// plus per-scenario checks of the memory handshake, stall, branch and error outputs.
module tb_mem_access_stage;

    localparam logic [3:0] T_NOP    = 4'd0;
    localparam logic [3:0] T_ALU    = 4'd1;
    localparam logic [3:0] T_LOAD   = 4'd3;
    localparam logic [3:0] T_STORE  = 4'd4;
    localparam logic [3:0] T_BRANCH = 4'd5;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [3:0]  num;
        logic [3:0]  typ;
    } exp_t;

    logic        clock, reset;
    logic [31:0] In_Inst, In_NewPC, In_RegDataB, In_ALUOutput;
    logic        In_Condition;
    logic [3:0]  In_InstNum, In_InstType;
    logic        Dmem_Req, Dmem_We, Dmem_Ack;
    logic [31:0] Dmem_Addr, Dmem_WData, Dmem_RData;
    logic        Stall, BranchTaken, BusError;
    logic [31:0] BranchTarget;
    logic        Out_Valid;
    logic [31:0] Out_Inst, Out_ALUOutput, Out_MemData;
    logic [3:0]  Out_InstNum, Out_InstType;

    int   checks = 0;
    int   passes = 0;
    exp_t sb_q[$];
    exp_t mon_exp, mon_got;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .In_Inst      (In_Inst),
        .In_NewPC     (In_NewPC),
        .In_RegDataB  (In_RegDataB),
        .In_ALUOutput (In_ALUOutput),
        .In_Condition (In_Condition),
        .In_InstNum   (In_InstNum),
        .In_InstType  (In_InstType),
        .Dmem_Req     (Dmem_Req),
        .Dmem_We      (Dmem_We),
        .Dmem_Addr    (Dmem_Addr),
        .Dmem_WData   (Dmem_WData),
        .Dmem_RData   (Dmem_RData),
        .Dmem_Ack     (Dmem_Ack),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .BusError     (BusError),
        .Out_Valid    (Out_Valid),
        .Out_Inst     (Out_Inst),
        .Out_ALUOutput(Out_ALUOutput),
        .Out_MemData  (Out_MemData),
        .Out_InstNum  (Out_InstNum),
        .Out_InstType (Out_InstType)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every valid MEM/WB result must match the oldest pending expectation.
    always @(negedge clock) begin
        if (!reset && Out_Valid) begin
            checks++;
            mon_got = {Out_Inst, Out_ALUOutput, Out_MemData, Out_InstNum, Out_InstType};
            if (sb_q.size() == 0) begin
                $display("FAIL out_unexpected: got inst=%h alu=%h mem=%h num=%h type=%h, expected no output",
                         Out_Inst, Out_ALUOutput, Out_MemData, Out_InstNum, Out_InstType);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL out_result: got inst=%h alu=%h mem=%h num=%h type=%h, expected inst=%h alu=%h mem=%h num=%h type=%h",
                             mon_got.inst, mon_got.alu, mon_got.mem, mon_got.num, mon_got.typ,
                             mon_exp.inst, mon_exp.alu, mon_exp.mem, mon_exp.num, mon_exp.typ);
                else
                    passes++;
            end
        end
    end

    task automatic drive(input logic [3:0] typ, input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] regb, input logic [31:0] newpc, input logic cond,
                         input logic [3:0] num);
        In_InstType  = typ;
        In_Inst      = inst;
        In_ALUOutput = alu;
        In_RegDataB  = regb;
        In_NewPC     = newpc;
        In_Condition = cond;
        In_InstNum   = num;
    endtask

    task automatic drive_nop();
        drive(T_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    endtask

    // Holds the already-driven memory op until Stall drops, answering with an ack
    // on the cycle after the ack_at-th Req cycle (ack_at=0: never), then drives a NOP.
    task automatic run_mem_op(input int ack_at, input logic [31:0] rdata,
                              output int stall_cnt, output int req_cnt,
                              output int berr_cnt, output int berr_at,
                              output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                              output logic we_seen, output bit finished);
        stall_cnt = 0; req_cnt = 0; berr_cnt = 0; berr_at = -1; finished = 1'b0;
        addr_seen = 32'hx; wdata_seen = 32'hx; we_seen = 1'bx;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clock);
            if (Stall) stall_cnt++;
            if (Dmem_Req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    addr_seen = Dmem_Addr; wdata_seen = Dmem_WData; we_seen = Dmem_We;
                end
            end
            if (BusError) begin
                berr_cnt++;
                berr_at = req_cnt;
            end
            if (!Stall) begin
                finished = 1'b1;
                break;
            end
            @(posedge clock); #1;
            Dmem_Ack   = (ack_at != 0) && (req_cnt == ack_at);
            Dmem_RData = Dmem_Ack ? rdata : 32'h0;
        end
        @(posedge clock); #1;
        Dmem_Ack   = 1'b0;
        Dmem_RData = 32'h0;
        drive_nop();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Dmem_Ack = 1'b0; Dmem_RData = 32'h0;
        drive_nop();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (Out_Valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Out_Valid); else passes++;
        checks++; if ({Out_Inst, Out_ALUOutput, Out_MemData, Out_InstNum, Out_InstType} !== 104'h0)
            $display("FAIL reset_outs: got inst=%h alu=%h mem=%h expected all zero", Out_Inst, Out_ALUOutput, Out_MemData);
        else passes++;
        checks++; if (Dmem_Req !== 1'b0) $display("FAIL reset_req: got %b expected 0", Dmem_Req); else passes++;
        checks++; if (BusError !== 1'b0) $display("FAIL reset_buserr: got %b expected 0", BusError); else passes++;
        checks++; if (Stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", Stall); else passes++;
    endtask

    task automatic test_alu();
        logic stall_seen = 1'b0;
        @(posedge clock); #1;
        drive(T_ALU, 32'h0000_1033, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 4'd1);
        sb_q.push_back({32'h0000_1033, 32'h0000_1234, 32'h0, 4'd1, T_ALU});
        Dmem_Ack = 1'b1; Dmem_RData = 32'hFFFF_FFFF;  // stray ack outside WAIT
        @(negedge clock);
        stall_seen |= Stall;
        checks++; if (Dmem_Req !== 1'b0) $display("FAIL alu_req: got %b expected 0", Dmem_Req); else passes++;
        @(posedge clock); #1;
        drive(T_ALU, 32'h0000_2033, 32'h0000_5678, 32'h0, 32'h0, 1'b0, 4'd2);
        sb_q.push_back({32'h0000_2033, 32'h0000_5678, 32'h0, 4'd2, T_ALU});
        @(negedge clock);
        stall_seen |= Stall;
        checks++; if (Out_Valid !== 1'b1) $display("FAIL alu_latency: got Out_Valid=%b expected 1", Out_Valid); else passes++;
        @(posedge clock); #1;
        drive_nop();
        Dmem_Ack = 1'b0; Dmem_RData = 32'h0;
        @(negedge clock);
        stall_seen |= Stall;
        checks++; if (stall_seen !== 1'b0) $display("FAIL alu_stall: got %b expected 0", stall_seen); else passes++;
    endtask

    task automatic test_branch();
        @(posedge clock); #1;
        drive(T_BRANCH, 32'h0000_3063, 32'h0000_0200, 32'h0, 32'h0000_0100, 1'b1, 4'd3);
        sb_q.push_back({32'h0000_3063, 32'h0000_0200, 32'h0, 4'd3, T_BRANCH});
        @(negedge clock);
        checks++; if (BranchTaken !== 1'b1) $display("FAIL br_taken: got %b expected 1", BranchTaken); else passes++;
        checks++; if (BranchTarget !== 32'h100) $display("FAIL br_target: got %h expected 00000100", BranchTarget); else passes++;
        @(posedge clock); #1;
        drive(T_BRANCH, 32'h0000_4063, 32'h0000_0300, 32'h0, 32'h0000_0300, 1'b0, 4'd4);
        sb_q.push_back({32'h0000_4063, 32'h0000_0300, 32'h0, 4'd4, T_BRANCH});
        @(negedge clock);
        checks++; if (BranchTaken !== 1'b0) $display("FAIL br_not_taken: got %b expected 0", BranchTaken); else passes++;
        @(posedge clock); #1;
        drive_nop();
    endtask

    task automatic test_load();
        int sc, rc, bc, ba; logic [31:0] a, w; logic we; bit fin;
        @(posedge clock); #1;
        drive(T_LOAD, 32'h0000_5003, 32'h0000_0040, 32'h0, 32'h0, 1'b1, 4'd5);
        sb_q.push_back({32'h0000_5003, 32'h0000_0040, 32'hDEAD_BEEF, 4'd5, T_LOAD});
        run_mem_op(3, 32'hDEAD_BEEF, sc, rc, bc, ba, a, w, we, fin);
        checks++; if (!fin) $display("FAIL load_done: stall never released within budget"); else passes++;
        checks++; if (sc != 5) $display("FAIL load_stall: got %0d stall cycles expected 5", sc); else passes++;
        checks++; if (a !== 32'h40 || we !== 1'b0) $display("FAIL load_req: got addr=%h we=%b expected 00000040/0", a, we); else passes++;
        checks++; if (bc != 0) $display("FAIL load_buserr: got %0d pulses expected 0", bc); else passes++;
    endtask

    task automatic test_store();
        int sc, rc, bc, ba; logic [31:0] a, w; logic we; bit fin;
        @(posedge clock); #1;
        drive(T_STORE, 32'h0000_6023, 32'h0000_0080, 32'h0000_0055, 32'h0, 1'b0, 4'd6);
        sb_q.push_back({32'h0000_6023, 32'h0000_0080, 32'h0, 4'd6, T_STORE});
        run_mem_op(1, 32'h1234_5678, sc, rc, bc, ba, a, w, we, fin);
        checks++; if (a !== 32'h80 || w !== 32'h55 || we !== 1'b1)
            $display("FAIL store_req: got addr=%h wdata=%h we=%b expected 00000080/00000055/1", a, w, we);
        else passes++;
        checks++; if (sc != 3 || !fin) $display("FAIL store_stall: got %0d stall cycles expected 3", sc); else passes++;
    endtask

    task automatic test_timeout();
        int sc, rc, bc, ba; logic [31:0] a, w; logic we; bit fin;
        @(posedge clock); #1;
        drive(T_LOAD, 32'h0000_7003, 32'h0000_0044, 32'h0, 32'h0, 1'b0, 4'd7);
        sb_q.push_back({32'h0000_7003, 32'h0000_0044, 32'h0, 4'd7, T_LOAD});
        run_mem_op(0, 32'h0, sc, rc, bc, ba, a, w, we, fin);
        // One ACCESS cycle plus 16 WAIT cycles of Req; the error fires on the 17th.
        checks++; if (bc != 1 || ba != 17) $display("FAIL timeout_buserr: got %0d pulses at req cycle %0d expected 1 at 17", bc, ba); else passes++;
        checks++; if (sc != 18 || !fin) $display("FAIL timeout_stall: got %0d stall cycles expected 18", sc); else passes++;
        @(negedge clock);
        checks++; if (Dmem_Req !== 1'b0 || Stall !== 1'b0) $display("FAIL timeout_idle: got req=%b stall=%b expected 0/0", Dmem_Req, Stall); else passes++;
    endtask

    task automatic test_ack_on_last_cycle();
        int sc, rc, bc, ba; logic [31:0] a, w; logic we; bit fin;
        @(posedge clock); #1;
        drive(T_LOAD, 32'h0000_8003, 32'h0000_0048, 32'h0, 32'h0, 1'b0, 4'd8);
        sb_q.push_back({32'h0000_8003, 32'h0000_0048, 32'hCAFE_F00D, 4'd8, T_LOAD});
        run_mem_op(16, 32'hCAFE_F00D, sc, rc, bc, ba, a, w, we, fin);
        checks++; if (bc != 0) $display("FAIL lastack_buserr: got %0d pulses expected 0", bc); else passes++;
        checks++; if (sc != 18 || !fin) $display("FAIL lastack_stall: got %0d stall cycles expected 18", sc); else passes++;
    endtask

    task automatic test_misaligned();
        int sc, rc, bc, ba; logic [31:0] a, w; logic we; bit fin;
        @(posedge clock); #1;
        drive(T_LOAD, 32'h0000_9003, 32'h0000_0042, 32'h0, 32'h0, 1'b0, 4'd9);
`ifdef MEM_ALIGN_CHECK_EN
        sb_q.push_back({32'h0000_9003, 32'h0000_0042, 32'h0, 4'd9, T_LOAD});
        run_mem_op(0, 32'h0, sc, rc, bc, ba, a, w, we, fin);
        checks++; if (bc != 1 || ba != 0 || rc != 0) $display("FAIL align_err: got %0d pulses, %0d req cycles expected 1 pulse, 0 req", bc, rc); else passes++;
        checks++; if (sc != 0 || !fin) $display("FAIL align_stall: got %0d stall cycles expected 0", sc); else passes++;
`else
        sb_q.push_back({32'h0000_9003, 32'h0000_0042, 32'h0BAD_F00D, 4'd9, T_LOAD});
        run_mem_op(1, 32'h0BAD_F00D, sc, rc, bc, ba, a, w, we, fin);
        checks++; if (rc == 0 || a !== 32'h42) $display("FAIL align_access: got %0d req cycles addr=%h expected access at 00000042", rc, a); else passes++;
        checks++; if (bc != 0 || !fin) $display("FAIL align_buserr: got %0d pulses expected 0", bc); else passes++;
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic req_after = 1'b0;
        @(posedge clock); #1;
        drive(T_LOAD, 32'h0000_A003, 32'h0000_0050, 32'h0, 32'h0, 1'b0, 4'd10);
        repeat (3) @(posedge clock);
        #1;
        checks++; if (Dmem_Req !== 1'b1) $display("FAIL rstwait_pre: got req=%b expected 1 in WAIT", Dmem_Req); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (Dmem_Req !== 1'b0 || Stall !== 1'b0 || Out_Valid !== 1'b0)
            $display("FAIL rstwait_now: got req=%b stall=%b valid=%b expected 0/0/0", Dmem_Req, Stall, Out_Valid);
        else passes++;
        drive_nop();
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            req_after |= Dmem_Req;
        end
        checks++; if (req_after !== 1'b0) $display("FAIL rstwait_retry: got req=%b after reset expected 0", req_after); else passes++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_timeout();
        test_ack_on_last_cycle();
        test_misaligned();
        test_reset_mid_wait();
        repeat (3) @(negedge clock);
        checks++; if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending results expected 0", sb_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
